// File: rtl/membus_init.sv
// Memory-bus initiator: one read, write or read-modify-write cycle per accepted start.
// Words use PDP-10 numbering (bit 0 = MSB), so spec bit b of a 36-bit word is [35-b] here.
module membus_init #(
    parameter int WR_SETUP = 8,
    parameter int WR_HOLD  = 4,
    parameter int TIMEOUT  = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cmd_rd,
    input  logic        cmd_wr,
    input  logic [17:0] addr,
    input  logic [35:0] wdata,
    input  logic        wdata_valid,
    input  logic        fm_enable,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [35:0] rdata,
    output logic        membus_rq_cyc,
    output logic        membus_rd_rq,
    output logic        membus_wr_rq,
    output logic        membus_wr_rs,
    output logic [14:0] membus_ma,
    output logic [3:0]  membus_sel,
    output logic        membus_fmc_select,
    output logic [35:0] membus_mb_out,
    input  logic        membus_addr_ack,
    input  logic        membus_rd_rs,
    input  logic [35:0] membus_mb_in
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RQ     = 3'd1;
    localparam logic [2:0] S_RDWAIT = 3'd2;
    localparam logic [2:0] S_WRWAIT = 3'd3;
    localparam logic [2:0] S_WRCLR  = 3'd4;
    localparam logic [2:0] S_WRDATA = 3'd5;
    localparam logic [2:0] S_WRRS   = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    // One counter serves both the ack timeout and the write setup/hold phases.
    localparam int CNT_MAX = (TIMEOUT > WR_SETUP) ? ((TIMEOUT > WR_HOLD) ? TIMEOUT : WR_HOLD)
                                                  : ((WR_SETUP > WR_HOLD) ? WR_SETUP : WR_HOLD);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(WR_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(WR_HOLD - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [17:0]   addr_q, addr_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic          fmc_q, fmc_d;
    logic [35:0]   wdata_q, wdata_d;
    logic [35:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        fmc_d   = fmc_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start && (cmd_rd || cmd_wr)) begin
                    addr_d  = addr;
                    rd_d    = cmd_rd;
                    wr_d    = cmd_wr;
                    wdata_d = wdata;
                    fmc_d   = fm_enable && (addr[17:4] == 14'd0);
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RQ;
                end
            end
            S_RQ: begin
                if (membus_addr_ack) begin
                    cnt_d   = '0;
                    state_d = rd_q ? S_RDWAIT : S_WRCLR;
                end else if (cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RDWAIT: begin
                if (membus_rd_rs) begin
                    rdata_d = membus_mb_in;
                    cnt_d   = '0;
                    state_d = wr_q ? S_WRWAIT : S_DONE;
                end else if (cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WRWAIT: begin
                // Host may take arbitrarily long to supply the modified word.
                if (wdata_valid) begin
                    wdata_d = wdata;
                    cnt_d   = '0;
                    state_d = S_WRCLR;
                end
            end
            S_WRCLR: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WRDATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WRDATA: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WRRS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WRRS:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            fmc_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            fmc_q   <= fmc_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Bus outputs decode from state only, so an async reset silences them at once.
    logic bus_act;
    assign bus_act = (state_q != S_IDLE) && (state_q != S_DONE);

    assign busy              = bus_act;
    assign done              = (state_q == S_DONE);
    assign err               = err_q;
    assign rdata             = rdata_q;
    assign membus_rq_cyc     = (state_q == S_RQ);
    assign membus_rd_rq      = bus_act && rd_q;
    assign membus_wr_rq      = bus_act && wr_q;
    assign membus_wr_rs      = (state_q == S_WRRS);
    assign membus_ma         = bus_act ? addr_q[14:0] : 15'd0;
    assign membus_sel        = bus_act ? addr_q[17:14] : 4'd0;
    assign membus_fmc_select = bus_act && fmc_q;
    assign membus_mb_out     = ((state_q == S_WRDATA) || (state_q == S_WRRS)) ? wdata_q : 36'd0;

endmodule

// File: tb/tb_membus_init.sv
// Randomized bench for membus_init: a per-cycle schedule model predicts every bus output.
module tb_membus_init;
    localparam int WR_SETUP = 8;
    localparam int WR_HOLD  = 4;
    localparam int TIMEOUT  = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, cmd_rd, cmd_wr, wdata_valid, fm_enable;
    logic [17:0] addr;
    logic [35:0] wdata;
    logic        busy, done, err;
    logic [35:0] rdata;
    logic        membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_wr_rs;
    logic [14:0] membus_ma;
    logic [3:0]  membus_sel;
    logic        membus_fmc_select;
    logic [35:0] membus_mb_out;
    logic        membus_addr_ack, membus_rd_rs;
    logic [35:0] membus_mb_in;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [35:0] exp_rdata;

    always #5 clk = ~clk;

    membus_init #(.WR_SETUP(WR_SETUP), .WR_HOLD(WR_HOLD), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .start(start), .cmd_rd(cmd_rd), .cmd_wr(cmd_wr),
        .addr(addr), .wdata(wdata), .wdata_valid(wdata_valid), .fm_enable(fm_enable),
        .busy(busy), .done(done), .err(err), .rdata(rdata),
        .membus_rq_cyc(membus_rq_cyc), .membus_rd_rq(membus_rd_rq),
        .membus_wr_rq(membus_wr_rq), .membus_wr_rs(membus_wr_rs),
        .membus_ma(membus_ma), .membus_sel(membus_sel),
        .membus_fmc_select(membus_fmc_select), .membus_mb_out(membus_mb_out),
        .membus_addr_ack(membus_addr_ack), .membus_rd_rs(membus_rd_rs),
        .membus_mb_in(membus_mb_in)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic b, input logic d, input logic rq,
                                         input logic rr, input logic wr, input logic rs,
                                         input logic f, input logic [3:0] s,
                                         input logic [14:0] m, input logic [35:0] mb);
        return {2'b00, b, d, rq, rr, wr, rs, f, s, m, mb};
    endfunction

    function automatic logic [63:0] dut_snap();
        return pack(busy, done, membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_wr_rs,
                    membus_fmc_select, membus_sel, membus_ma, membus_mb_out);
    endfunction

    function automatic logic [35:0] junk36();
        return {4'($urandom()), $urandom()};
    endfunction

    task automatic clear_inputs();
        start = 0; cmd_rd = 0; cmd_wr = 0; addr = '0; wdata = '0;
        wdata_valid = 0; fm_enable = 0;
        membus_addr_ack = 0; membus_rd_rs = 0; membus_mb_in = '0;
    endtask

    // k: RQ cycles before ack (0 = never). r: RDWAIT cycles (0 = never).
    // w: WRWAIT cycles for RMW. Cycle t=0 is the first cycle after start is taken.
    task automatic run_txn(input bit rd, input bit wr, input logic [17:0] a,
                           input logic [35:0] wd, input bit fm, input int k, input int r,
                           input int w, input logic [35:0] mbin, input logic [35:0] wd2,
                           input bit noise, input int abort_at);
        int          done_t, w0, rs_t, wv_t, rd_lim;
        bit          tmo, has_wr, in_bus, rdwin, wrwin;
        logic        fmc;
        logic [35:0] exp_data, exp_mb;
        logic [63:0] exp;
        tmo = 0; w0 = 0; rs_t = -1; wv_t = -1;
        if (k == 0) begin
            tmo = 1; done_t = TIMEOUT;
        end else if (rd && r == 0) begin
            tmo = 1; done_t = k + TIMEOUT;
        end else begin
            if (rd) rs_t = k + r - 1;
            if (rd && wr) wv_t = k + r + w - 1;
            w0 = (rd && wr) ? k + r + w : k;
            done_t = wr ? w0 + WR_SETUP + WR_HOLD + 1 : k + r;
        end
        has_wr   = wr && !tmo;
        exp_data = (rd && wr) ? wd2 : wd;
        fmc      = fm && (a[17:4] == 14'd0);
        rd_lim   = (r == 0) ? k + TIMEOUT : k + r;

        cmd_rd = rd; cmd_wr = wr; addr = a; wdata = wd; fm_enable = fm; start = 1;
        @(negedge clk);
        for (int t = 0; t <= done_t + 1; t++) begin
            if (t == abort_at) return;
            in_bus = (t < done_t);
            exp_mb = (has_wr && t >= w0 + WR_SETUP && t <= w0 + WR_SETUP + WR_HOLD) ? exp_data : 36'd0;
            exp = pack(in_bus, t == done_t, in_bus && (k == 0 || t < k), in_bus && rd,
                       in_bus && wr, has_wr && (t == w0 + WR_SETUP + WR_HOLD), in_bus && fmc,
                       in_bus ? a[17:14] : 4'd0, in_bus ? a[14:0] : 15'd0, exp_mb);
            check($sformatf("bus t=%0d", t), dut_snap(), exp);
            if (t == done_t) begin
                check("err", 64'(err), 64'(tmo));
                if (rd && !tmo) exp_rdata = mbin;
                check("rdata", 64'(rdata), 64'(exp_rdata));
            end
            rdwin = rd && k != 0 && t >= k && t < rd_lim;
            wrwin = rd && wr && !tmo && t >= k + r && t <= wv_t;
            start           = 0;
            membus_addr_ack = (k != 0 && t == k - 1);
            membus_rd_rs    = (t == rs_t);
            wdata_valid     = (t == wv_t);
            membus_mb_in    = (t == rs_t) ? mbin : junk36();
            wdata           = (t == wv_t) ? wd2 : junk36();
            if (noise && in_bus) begin
                // Strobes outside their windows and a competing start must all be ignored.
                if (k != 0 && t >= k && $urandom_range(3) == 0) membus_addr_ack = 1;
                if (!rdwin && $urandom_range(3) == 0) membus_rd_rs = 1;
                if (!wrwin && $urandom_range(3) == 0) wdata_valid = 1;
                if (t == 2) begin
                    start = 1; cmd_rd = 1'($urandom_range(1)); cmd_wr = 1;
                    addr = 18'($urandom()); fm_enable = 1'($urandom_range(1));
                end
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    initial begin
        bit          rd, wr;
        logic [17:0] a;
        clear_inputs();
        reset = 1;
        exp_rdata = '0;
        #1;
        check("reset bus", dut_snap(), 64'd0);
        check("reset rdata", 64'(rdata), 64'd0);
        check("reset err", 64'(err), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        check("idle after reset", dut_snap(), 64'd0);

        start = 1;
        @(negedge clk);
        start = 0;
        check("start no cmd", dut_snap(), 64'd0);
        @(negedge clk);
        check("start no cmd 2", dut_snap(), 64'd0);

        run_txn(1, 0, 18'o000005, 36'd0, 1, 3, 2, 0, 36'o123456654321, 36'd0, 0, -1);
        run_txn(0, 1, 18'o740012, 36'o777000000777, 0, 2, 0, 0, 36'd0, 36'd0, 0, -1);
        run_txn(1, 1, 18'o001234, 36'o555, 1, 2, 3, 4, 36'o42, 36'o1, 0, -1);
        run_txn(0, 1, 18'o000012, 36'o7, 1, 0, 0, 0, 36'd0, 36'd0, 0, -1);
        run_txn(1, 0, 18'o000003, 36'd0, 1, 2, 0, 0, 36'o1, 36'd0, 1, -1);

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(2))
                0:       begin rd = 1; wr = 0; end
                1:       begin rd = 0; wr = 1; end
                default: begin rd = 1; wr = 1; end
            endcase
            a = 18'($urandom());
            if ($urandom_range(1) == 1) a = a & 18'o17;
            run_txn(rd, wr, a, junk36(), 1'($urandom_range(1)), $urandom_range(1, 6),
                    $urandom_range(1, 5), $urandom_range(1, 5), junk36(), junk36(), 1, -1);
        end

        // Abort a write in its data phase; reset must clear everything without a clock edge.
        run_txn(0, 1, 18'o000100, 36'o765432101234, 0, 2, 0, 0, 36'd0, 36'd0, 0,
                2 + WR_SETUP + 1);
        check("pre-reset mb_out", 64'(membus_mb_out), 64'(36'o765432101234));
        clear_inputs();
        #2 reset = 1;
        #1;
        check("async reset bus", dut_snap(), 64'd0);
        check("async reset rdata", 64'(rdata), 64'd0);
        check("async reset err", 64'(err), 64'd0);
        exp_rdata = '0;
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("quiet after reset %0d", i), dut_snap(), 64'd0);
        end
        run_txn(1, 0, 18'o000777, 36'd0, 1, 1, 1, 0, 36'o707070707070, 36'd0, 1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
